// File: rtl/jk_ff_bank.sv
// WIDTH-bit bank of JK cells with run-time JK / D / T / COUNT personality, change-detect and
// terminal-count status. Define JK_TOGGLE_STAT_EN to add the saturating toggle_cnt output.
module jk_ff_bank #(
    parameter int unsigned WIDTH     = 4,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             changed,
    output logic             tc
`ifdef JK_TOGGLE_STAT_EN
    ,
    output logic [15:0]      toggle_cnt
`endif
);

    localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

    localparam logic [1:0] MODE_JK  = 2'b00;
    localparam logic [1:0] MODE_D   = 2'b01;
    localparam logic [1:0] MODE_T   = 2'b10;
    localparam logic [1:0] MODE_CNT = 2'b11;

    logic [WIDTH-1:0] j_eff;
    logic [WIDTH-1:0] k_eff;
    logic [WIDTH-1:0] q_next;
    logic             carry;
    logic             update;

    // Map each mode onto plain JK controls; COUNT ripples the all-ones carry from bit 0 up.
    always_comb begin
        j_eff = '0;
        k_eff = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode)
                MODE_JK: begin
                    j_eff[i] = J[i];
                    k_eff[i] = K[i];
                end
                MODE_D: begin
                    j_eff[i] = J[i];
                    k_eff[i] = ~J[i];
                end
                MODE_T: begin
                    j_eff[i] = J[i];
                    k_eff[i] = J[i];
                end
                default: begin
                    j_eff[i] = carry;
                    k_eff[i] = carry;
                end
            endcase
            carry = carry & Q[i];
        end
    end

    always_comb begin
        q_next = Q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({j_eff[i], k_eff[i]})
                2'b00:   q_next[i] = Q[i];
                2'b01:   q_next[i] = 1'b0;
                2'b10:   q_next[i] = 1'b1;
                default: q_next[i] = ~Q[i];
            endcase
        end
    end

    assign update = en && (q_next != Q);

    always_ff @(posedge clock) begin
        if (reset) begin
            Q       <= RST_Q;
            changed <= 1'b0;
        end else begin
            if (en) begin
                Q <= q_next;
            end
            changed <= update;
        end
    end

    assign Qn = ~Q;
    assign tc = (mode == MODE_CNT) && en && (&Q);

`ifdef JK_TOGGLE_STAT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            toggle_cnt <= 16'h0000;
        end else if (update && (toggle_cnt != 16'hFFFF)) begin
            toggle_cnt <= toggle_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_jk_ff_bank.sv
// Scoreboard bench for jk_ff_bank: driver pushes model predictions, monitor pops and compares.
// Also exercises toggle_cnt when JK_TOGGLE_STAT_EN is defined.
module tb_jk_ff_bank;

    localparam int unsigned W  = 4;
    localparam logic [3:0]  RV = 4'b1010;

    logic         clock;
    logic         reset;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] J;
    logic [W-1:0] K;
    logic [W-1:0] Q;
    logic [W-1:0] Qn;
    logic         changed;
    logic         tc;
`ifdef JK_TOGGLE_STAT_EN
    logic [15:0]  toggle_cnt;
`endif

    jk_ff_bank #(
        .WIDTH     (W),
        .RESET_VAL ({28'd0, RV})
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .mode    (mode),
        .J       (J),
        .K       (K),
        .Q       (Q),
        .Qn      (Qn),
        .changed (changed),
        .tc      (tc)
`ifdef JK_TOGGLE_STAT_EN
        ,
        .toggle_cnt (toggle_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        pre_valid;
        logic [3:0]  cur_q;
        logic        tc;
        logic [3:0]  nq;
        logic        ch;
        int unsigned cnt;
    } rec_t;

    rec_t        sb[$];
    int unsigned vectors = 0;
    int unsigned nchecks = 0;
    int unsigned nfail   = 0;

    // Reference model state
    logic [3:0]  m_q     = 4'h0;
    logic        m_valid = 1'b0;
    int unsigned m_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [3:0] j, input logic [3:0] k);
        rec_t       rec;
        logic [3:0] nq;
        @(posedge clock);
        #2;
        reset = r;
        en    = e;
        mode  = m;
        J     = j;
        K     = k;
        rec.pre_valid = m_valid;
        rec.cur_q     = m_q;
        rec.tc        = (m == 2'b11) && e && (m_q == 4'hF);
        if (r) begin
            m_q     = RV;
            m_valid = 1'b1;
            m_cnt   = 0;
            rec.ch  = 1'b0;
        end else if (e) begin
            case (m)
                2'b00:   nq = (j & ~m_q) | (~k & m_q);  // Q+ = J Q' + K' Q
                2'b01:   nq = j;
                2'b10:   nq = m_q ^ j;
                default: nq = 4'((int'(m_q) + 1) % 16);
            endcase
            rec.ch = (nq != m_q);
            if (rec.ch && m_cnt < 65535) m_cnt++;
            m_q = nq;
        end else begin
            rec.ch = 1'b0;
        end
        rec.nq  = m_q;
        rec.cnt = m_cnt;
        sb.push_back(rec);
        vectors++;
    endtask

    // Monitor: combinational outputs before the edge, registered outputs just after it.
    initial begin
        rec_t       r;
        logic [3:0] exp_qn;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                r = sb.pop_front();
                if (r.pre_valid) begin
                    exp_qn = ~r.cur_q;
                    chk("q_pre", {28'd0, Q}, {28'd0, r.cur_q});
                    chk("qn_pre", {28'd0, Qn}, {28'd0, exp_qn});
                    chk("tc", {31'd0, tc}, {31'd0, r.tc});
                end
                @(posedge clock);
                #1;
                exp_qn = ~r.nq;
                chk("q", {28'd0, Q}, {28'd0, r.nq});
                chk("qn", {28'd0, Qn}, {28'd0, exp_qn});
                chk("changed", {31'd0, changed}, {31'd0, r.ch});
`ifdef JK_TOGGLE_STAT_EN
                chk("toggle_cnt", {16'd0, toggle_cnt}, {16'd0, r.cnt[15:0]});
`endif
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        mode  = 2'b00;
        J     = '0;
        K     = '0;

        // Reset wins over en/JK toggle controls
        step(1'b1, 1'b1, 2'b00, 4'hF, 4'hF);
        // Clear to 0000 via D, then the JK sequence
        step(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000);
        step(1'b0, 1'b1, 2'b00, 4'b0011, 4'b0000);
        step(1'b0, 1'b1, 2'b00, 4'b0000, 4'b0001);
        step(1'b0, 1'b1, 2'b00, 4'b1111, 4'b1111);
        step(1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000);
        // D then T
        step(1'b0, 1'b1, 2'b01, 4'b0110, 4'b1001);
        step(1'b0, 1'b1, 2'b10, 4'b0101, 4'b1111);
        step(1'b0, 1'b1, 2'b10, 4'b0101, 4'b0000);
        step(1'b0, 1'b1, 2'b10, 4'b0000, 4'b1111);
        // COUNT through the wrap, then hold with en low
        step(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 2'b11, 4'($urandom), 4'($urandom));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b11, 4'hF, 4'hF);
        // Park on 1111 with en low: tc must stay low
        step(1'b0, 1'b1, 2'b01, 4'b1111, 4'b0000);
        step(1'b0, 1'b0, 2'b11, 4'b0000, 4'b0000);
        step(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000);
        // Reset mid-count at 0111, then resume
        step(1'b0, 1'b1, 2'b01, 4'b0110, 4'b0000);
        step(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000);
        step(1'b1, 1'b1, 2'b11, 4'b0000, 4'b0000);
        step(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000);
        step(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000);

        // Randomized mix of modes, enables and occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom), 4'($urandom), 4'($urandom));
        end

`ifdef JK_TOGGLE_STAT_EN
        step(1'b1, 1'b1, 2'b11, 4'h0, 4'h0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 2'b11, 4'h0, 4'h0);
        step(1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
        for (int i = 0; i < 70000; i++) step(1'b0, 1'b1, 2'b11, 4'h0, 4'h0);
        step(1'b0, 1'b1, 2'b10, 4'hF, 4'h0);
`endif

        repeat (2) @(posedge clock);
        #3;
        chk("scoreboard_drain", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, nfail);
        $finish;
    end

endmodule
